// File: rtl/serial_parity_checker_if.sv
// Bundle for the serial parity receiver: serial bit input, valid/ready word output and status.
interface serial_parity_checker_if #(
  parameter int DATA_W = 8
);
  logic              bit_in;
  logic              bit_valid;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    output bit_in, bit_valid, out_ready,
    input  data_out, out_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    input  bit_in, bit_valid, out_ready,
    output data_out, out_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_parity_checker.sv
// Deframes start/data(LSB first)/parity/stop and checks parity; word appears one cycle after the stop bit.
// One-entry valid/ready output register; a frame finishing while the register is still held is dropped and flagged by overrun.
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_parity_checker_if.slave bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              perr;

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              perr_q;
  logic              ferr_q;
  logic              overrun_q;

  logic              done;
  logic              reg_free;

  assign done     = (state == STOP) && bus.bit_valid;
  // A word leaving this very cycle frees the register for the completing frame.
  assign reg_free = !valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else if (bus.bit_valid) begin
      case (state)
        IDLE: begin
          if (!bus.bit_in) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          shreg[cnt] <= bus.bit_in;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST_BIT) state <= PARITY;
        end
        PARITY: begin
          perr  <= ^shreg ^ bus.bit_in ^ PARITY_ODD;
          state <= STOP;
        end
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= done && !reg_free;
      if (done && reg_free) begin
        valid_q <= 1'b1;
        data_q  <= shreg;
        perr_q  <= perr;
        ferr_q  <= !bus.bit_in;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd instances share stimulus, a queue scoreboard checks each accepted word.
module tb_serial_parity_checker;
  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_parity_checker_if #(.DATA_W(8)) ife ();
  serial_parity_checker_if #(.DATA_W(8)) ifo ();

  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .bus(ife.slave)
  );
  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bus(ifo.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   ov_e   = 0;
  int   ov_o   = 0;
  exp_t qe[$];
  exp_t qo[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input logic pbit, input logic stop, input bit odd);
    exp_t r;
    int ones;
    ones = int'(pbit);
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    r.d  = d;
    r.pe = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    r.fe = !stop;
    return r;
  endfunction

  task automatic drive(input logic b, input logic v);
    ife.bit_in = b;  ifo.bit_in = b;
    ife.bit_valid = v; ifo.bit_valid = v;
  endtask

  task automatic set_ready(input logic r);
    ife.out_ready = r;
    ifo.out_ready = r;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0);
    end
  endtask

  // Leaves the stop bit on the line; the caller's next cycle samples it.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input bit toggle, input bit push, input bit rdy_stop);
    logic [10:0] bits;
    bits = {stop, pbit, d, 1'b0};
    if (push) begin
      qe.push_back(model(d, pbit, stop, 1'b0));
      qo.push_back(model(d, pbit, stop, 1'b1));
    end
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (i == 10 && rdy_stop) set_ready(1'b1);
      drive(bits[i], 1'b1);
      if (toggle) begin
        @(posedge clk); #1;
        drive(~bits[i], 1'b0);
        if (i < 10) check("busy_gap", 32'(ife.busy), 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ife.overrun) ov_e++;
      if (ifo.overrun) ov_o++;
      if (ife.out_valid && ife.out_ready) begin
        if (qe.size() == 0) check("even_unexpected_word", 32'(qe.size()), 32'd1);
        else begin
          exp_t e;
          e = qe.pop_front();
          check("even_data", 32'(ife.data_out), 32'(e.d));
          check("even_parity_err", 32'(ife.parity_err), 32'(e.pe));
          check("even_frame_err", 32'(ife.frame_err), 32'(e.fe));
        end
      end
      if (ifo.out_valid && ifo.out_ready) begin
        if (qo.size() == 0) check("odd_unexpected_word", 32'(qo.size()), 32'd1);
        else begin
          exp_t e;
          e = qo.pop_front();
          check("odd_data", 32'(ifo.data_out), 32'(e.d));
          check("odd_parity_err", 32'(ifo.parity_err), 32'(e.pe));
          check("odd_frame_err", 32'(ifo.frame_err), 32'(e.fe));
        end
      end
    end
  end

  initial begin
    int ov0;
    rst_n = 1'b0;
    drive(1'b1, 1'b0);
    set_ready(1'b1);
    #12;
    check("rst_out_valid", 32'(ife.out_valid), 32'd0);
    check("rst_data_out", 32'(ife.data_out), 32'd0);
    check("rst_parity_err", 32'(ife.parity_err), 32'd0);
    check("rst_frame_err", 32'(ife.frame_err), 32'd0);
    check("rst_overrun", 32'(ife.overrun), 32'd0);
    check("rst_busy", 32'(ife.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Clean even frame, latency and single-cycle valid
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0);
    check("t1_valid_after_stop", 32'(ife.out_valid), 32'd1);
    check("t1_busy_after_stop", 32'(ife.busy), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_one_cycle", 32'(ife.out_valid), 32'd0);
    idle(2);

    // Wrong even parity (correct for odd)
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Bad stop bit, then a back-to-back good frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);

    // bit_valid toggling with junk on the idle cycles
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Back-pressure and overrun
    set_ready(1'b0);
    ov0 = ov_e;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("t5_held_valid", 32'(ife.out_valid), 32'd1);
    check("t5_held_data", 32'(ife.data_out), 32'h11);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("t5_overrun_even", 32'(ov_e - ov0), 32'd1);
    check("t5_overrun_odd", 32'(ov_o - ov0), 32'd1);
    check("t5_data_kept", 32'(ife.data_out), 32'h11);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(3);
    check("t5_no_overrun_on_free", 32'(ov_e - ov0), 32'd1);

    // Reset while holding a word and mid-frame
    set_ready(1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("t6_holding", 32'(ife.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive((i == 0) ? 1'b0 : 1'b1, 1'b1);
    end
    @(posedge clk); #1;
    check("t6_busy_mid_frame", 32'(ife.busy), 32'd1);
    rst_n = 1'b0;
    drive(1'b1, 1'b0);
    #1;
    check("t6_rst_valid", 32'(ife.out_valid), 32'd0);
    check("t6_rst_busy", 32'(ife.busy), 32'd0);
    check("t6_rst_data", 32'(ife.data_out), 32'd0);
    check("t6_rst_overrun", 32'(ife.overrun), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_ready(1'b1);
    idle(2);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);

    for (int n = 0; n < 50 && (qe.size() != 0 || qo.size() != 0); n++) idle(1);
    check("even_queue_drained", 32'(qe.size()), 32'd0);
    check("odd_queue_drained", 32'(qo.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
